a_register_88: RTL and testbench
================================

# a_register_88

Bit-serial, 56-bit circulating A register with the 4-bit holding and decimal-correction stage that sits directly downstream of `serial_adder_84`. Each bit time it captures the uncorrected (`SUM1`) and corrected (`SUM2`) sum bits of the current digit. At T4 it commits whichever digit `USE_SUM2` selects. It recirculates the word so the register's LSbit output feeds the adder's `X_IN` on the next word cycle.

## Interface
- `WordDigits`, 14: BCD digits per word; word length is 4×`WordDigits` bits.
- `PHI2` input 1: bit-rate clock; all state changes on its rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `SUM1` input 1: uncorrected serial sum/difference from the adder.
- `SUM2` input 1: decimal-corrected serial sum from the adder.
- `USE_SUM2` input 1: valid during T4; selects the corrected digit.
- `T1`..`T4` input 1 each: one-hot bit-in-digit strobes; T1 is the LSbit.
- `FIRST_BIT` input 1: first bit period of a word cycle; coincides with T1.
- `WRITE_EN` input 1: 1 = commit adder results; 0 = recirculate the register's own contents unchanged.
- `A_OUT` output 1: serial register LSbit; goes to the adder `X_IN`.
- `DIGIT_OUT` output 4: last committed digit, i.e. the staging register contents.
- `WORD_ZERO` output 1: 1 if every digit committed in the previous word was 0000.

## Operation
- State:
  - main shift register `m[4·WordDigits−5:0]`
  - holding `h[2:0]`, which takes `SUM1` or `A_OUT`
  - correction `c[2:0]`, which takes `SUM2`
  - staging `s[3:0]`
  - zero accumulator `z`
- Every `PHI2` edge: `m` shifts right and `m`'s MSbit receives `s[0]`; `s` shifts right with zero fill. `A_OUT` = `m[0]`.
- Bit source `b` = `WRITE_EN ? SUM1 : A_OUT`.
- On T1/T2/T3 edges: the bit `b` is captured into `h` and `SUM2` into `c`, at index 0/1/2 respectively.
- On the T4 edge: `s` ← (`WRITE_EN` & `USE_SUM2`) ? {`SUM2`, `c`} : {`b`, `h`}. The parallel load overrides the shift of `s`.
- Circulation length is exactly 4·`WordDigits` cycles: a bit on `A_OUT` at cycle t returns to `A_OUT` at t+56 (default) when `WRITE_EN`=0.
- Zero detect:
  - At the T4 edge, `z` ← (`FIRST_BIT`-word start ? 1 : `z`) & (committed digit == 0).
  - At the T4 edge of the last digit, `WORD_ZERO` ← the final `z`.
  - The word start is latched from `FIRST_BIT` at T1.
- No T strobe asserted: no capture or commit; shifting continues.
- More than one T strobe asserted: priority is T1 > T2 > T3 > T4.
- `WRITE_EN` is sampled per bit. Toggling it mid-digit yields a digit mixing both sources, deterministically per the rules above; the controller must hold it constant for a whole digit.

## Timing
- Reset values:
  - `m`, `h`, `c`, `s` = 0
  - `z` = 1
  - `WORD_ZERO` = 1
  - `A_OUT` = 0
  - `DIGIT_OUT` = 0
- Reset asserted mid-word clears everything immediately. After release, circulation restarts on the next edge; the digit alignment is owned by the T-strobe source.
- Commit latency: `DIGIT_OUT` is valid the cycle after T4 and holds through the next T4 edge, shifting during that time.
- Digit d, with its bit 0 on `A_OUT` at T1 of digit d, is rewritten so that its new bit 0 appears on `A_OUT` at T1 of digit d in the next word.
- `WORD_ZERO` updates only on the last digit's T4 edge; it is stable for the following full word.

## Structure
- Shared package: `WordDigits` default, `DigitBits`=4, the `WordBits` derivation, and a BCD-zero constant.
- One sub-module, `digit_stage_86`, is natural. It contains `h`, `c`, `s` and the T4 select. Its ports are `SUM1`/`SUM2`/`USE_SUM2`/`T1`-`T4`/`WRITE_EN`/`A_OUT` in, and the serial stage output plus `DIGIT_OUT` out.
- The top level holds `m`, the zero detect and the word-start latch.

## Test plan
- Reset then free-run with `WRITE_EN`=0 for 112 cycles -> `A_OUT`=0 throughout; `WORD_ZERO`=1; `DIGIT_OUT`=0000.
- Digit 5+7 (adder drives `SUM1` bits 0,0,1,1 = 1100b, `SUM2` = 0010b, `USE_SUM2`=1 at T4) with `WRITE_EN`=1 -> `DIGIT_OUT`=0010 after T4; `A_OUT` emits 0,1,0,0 starting 56 cycles after that digit's T1.
- Digit 3+4 (`SUM1`=0111b, `USE_SUM2`=0) -> `DIGIT_OUT`=0111; the recirculated value is identical over three subsequent `WRITE_EN`=0 words.
- Load 14 digits 0x9876543210FEDC, then `WRITE_EN`=0 -> `A_OUT` reproduces the pattern bit-exact every 56 cycles; `WORD_ZERO`=0.
- Write all-zero word, then one word with digit 13 = 0001 -> `WORD_ZERO`=1 after the first word and 0 after the second, each changing only at the last T4.
- Assert `RESET` at bit 30 of a loaded word -> all outputs 0 and `WORD_ZERO`=1 asynchronously; the next word reads back all zeros.

Source files
------------

// File: rtl/a_register_88_pkg.sv
// Shared constants and helpers for the bit-serial A register and its digit stage.
package a_register_88_pkg;

  localparam int WORD_DIGITS_DEFAULT = 14;
  localparam int DIGIT_BITS          = 4;

  localparam logic [DIGIT_BITS-1:0] BCD_ZERO = '0;

  // Bit-in-digit phase after resolving overlapping strobes
  typedef enum logic [2:0] {
    PH_NONE,
    PH_T1,
    PH_T2,
    PH_T3,
    PH_T4
  } phase_e;

  // Word length in bits for a given digit count
  function automatic int word_bits(input int digits);
    return digits * DIGIT_BITS;
  endfunction

  // Resolve the strobes; an earlier bit position wins when several are high
  function automatic phase_e decode_phase(input logic t1, input logic t2,
                                          input logic t3, input logic t4);
    if (t1) return PH_T1;
    if (t2) return PH_T2;
    if (t3) return PH_T3;
    if (t4) return PH_T4;
    return PH_NONE;
  endfunction

endpackage

// File: rtl/digit_stage_86.sv
// Holding, correction and staging registers for one BCD digit.
// Bits 0..2 of the digit are parked in h (raw/recirculated) and c (corrected);
// at T4 the whole digit is committed to s, which then shifts out LSbit first.
module digit_stage_86
  import a_register_88_pkg::*;
(
  input  logic                  PHI2,
  input  logic                  RESET,
  input  logic                  SUM1,
  input  logic                  SUM2,
  input  logic                  USE_SUM2,
  input  logic                  T1,
  input  logic                  T2,
  input  logic                  T3,
  input  logic                  T4,
  input  logic                  WRITE_EN,
  input  logic                  A_OUT,
  output logic                  STAGE_OUT,
  output logic [DIGIT_BITS-1:0] DIGIT_OUT,
  output logic [DIGIT_BITS-1:0] COMMIT_DIGIT
);

  localparam int HoldBits = DIGIT_BITS - 1;

  phase_e                phase;
  logic                  bit_src;
  logic [HoldBits-1:0]   cap_en;
  logic [HoldBits-1:0]   h_vec;
  logic [HoldBits-1:0]   c_vec;
  logic [DIGIT_BITS-1:0] s_reg;

  assign phase   = decode_phase(T1, T2, T3, T4);
  // With writes disabled the register feeds back its own output unchanged
  assign bit_src = WRITE_EN ? SUM1 : A_OUT;

  // The digit that a T4 edge would commit (also used by the zero detector)
  assign COMMIT_DIGIT = (WRITE_EN & USE_SUM2) ? {SUM2, c_vec} : {bit_src, h_vec};

  assign STAGE_OUT = s_reg[0];
  assign DIGIT_OUT = s_reg;

  // One-hot capture enable for the three low bit positions
  always_comb begin
    cap_en = '0;
    case (phase)
      PH_T1:   cap_en = 3'b001;
      PH_T2:   cap_en = 3'b010;
      PH_T3:   cap_en = 3'b100;
      default: cap_en = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < HoldBits; gi++) begin : g_capture
      logic h_bit;
      logic c_bit;

      // Park the raw and corrected sum bits for this bit position
      always_ff @(posedge PHI2 or posedge RESET) begin
        if (RESET) begin
          h_bit <= 1'b0;
          c_bit <= 1'b0;
        end else if (cap_en[gi]) begin
          h_bit <= bit_src;
          c_bit <= SUM2;
        end
      end

      assign h_vec[gi] = h_bit;
      assign c_vec[gi] = c_bit;
    end
  endgenerate

  // Staging register: parallel load at T4, otherwise shift right with zero fill
  always_ff @(posedge PHI2 or posedge RESET) begin
    if (RESET) begin
      s_reg <= '0;
    end else if (phase == PH_T4) begin
      s_reg <= COMMIT_DIGIT;
    end else begin
      s_reg <= {1'b0, s_reg[DIGIT_BITS-1:1]};
    end
  end

endmodule

// File: rtl/a_register_88.sv
// Bit-serial circulating A register: main shift register plus digit stage
// form a loop of exactly WordBits cycles; also tracks whether the last
// committed word was all zero digits.
module a_register_88
  import a_register_88_pkg::*;
#(
  parameter int WordDigits = WORD_DIGITS_DEFAULT
) (
  input  logic                  PHI2,
  input  logic                  RESET,
  input  logic                  SUM1,
  input  logic                  SUM2,
  input  logic                  USE_SUM2,
  input  logic                  T1,
  input  logic                  T2,
  input  logic                  T3,
  input  logic                  T4,
  input  logic                  FIRST_BIT,
  input  logic                  WRITE_EN,
  output logic                  A_OUT,
  output logic [DIGIT_BITS-1:0] DIGIT_OUT,
  output logic                  WORD_ZERO
);

  localparam int WordBits = word_bits(WordDigits);
  // The staging register supplies the remaining DIGIT_BITS of the loop
  localparam int MainBits = WordBits - DIGIT_BITS;
  localparam int IdxW     = (WordDigits > 1) ? $clog2(WordDigits) : 1;

  logic [MainBits-1:0]   m_reg;
  logic                  stage_out;
  logic [DIGIT_BITS-1:0] commit_digit;
  phase_e                phase;

  logic                  word_start_reg;
  logic [IdxW-1:0]       digit_idx_reg;
  logic                  z_reg;
  logic                  word_zero_reg;
  logic                  z_next;
  logic                  last_digit;

  digit_stage_86 u_digit_stage (
    .PHI2         (PHI2),
    .RESET        (RESET),
    .SUM1         (SUM1),
    .SUM2         (SUM2),
    .USE_SUM2     (USE_SUM2),
    .T1           (T1),
    .T2           (T2),
    .T3           (T3),
    .T4           (T4),
    .WRITE_EN     (WRITE_EN),
    .A_OUT        (A_OUT),
    .STAGE_OUT    (stage_out),
    .DIGIT_OUT    (DIGIT_OUT),
    .COMMIT_DIGIT (commit_digit)
  );

  assign A_OUT     = m_reg[0];
  assign WORD_ZERO = word_zero_reg;
  assign phase     = decode_phase(T1, T2, T3, T4);

  assign last_digit = (digit_idx_reg == IdxW'(WordDigits - 1));
  // A new word restarts the accumulation regardless of the previous word
  assign z_next     = (word_start_reg ? 1'b1 : z_reg) & (commit_digit == BCD_ZERO);

  // Main circulating shift register, fed from the staging register
  always_ff @(posedge PHI2 or posedge RESET) begin
    if (RESET) begin
      m_reg <= '0;
    end else begin
      m_reg <= {stage_out, m_reg[MainBits-1:1]};
    end
  end

  // Word-start latch, digit position and zero accumulation
  always_ff @(posedge PHI2 or posedge RESET) begin
    if (RESET) begin
      word_start_reg <= 1'b0;
      digit_idx_reg  <= '0;
      z_reg          <= 1'b1;
      word_zero_reg  <= 1'b1;
    end else begin
      case (phase)
        PH_T1: begin
          word_start_reg <= FIRST_BIT;
          if (FIRST_BIT || last_digit) begin
            digit_idx_reg <= '0;
          end else begin
            digit_idx_reg <= digit_idx_reg + IdxW'(1);
          end
        end
        PH_T4: begin
          z_reg <= z_next;
          if (last_digit) begin
            word_zero_reg <= z_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a_register_88.sv
// Scoreboard bench for a_register_88: each 56-cycle word run pushes the word it
// commits and the per-digit staging values; the next run pops and compares them.
module tb_a_register_88;
  import a_register_88_pkg::*;

  localparam int WD = 14;
  localparam int WB = 56;

  logic       PHI2 = 1'b0;
  logic       RESET = 1'b1;
  logic       SUM1 = 1'b0;
  logic       SUM2 = 1'b0;
  logic       USE_SUM2 = 1'b0;
  logic       T1 = 1'b0;
  logic       T2 = 1'b0;
  logic       T3 = 1'b0;
  logic       T4 = 1'b0;
  logic       FIRST_BIT = 1'b0;
  logic       WRITE_EN = 1'b0;
  logic       A_OUT;
  logic [3:0] DIGIT_OUT;
  logic       WORD_ZERO;

  int checks   = 0;
  int failures = 0;

  logic [WB-1:0] word_q[$];
  logic [3:0]    digit_q[$];
  logic          wz_prev;

  always #5 PHI2 = ~PHI2;

  a_register_88 dut (
    .PHI2      (PHI2),
    .RESET     (RESET),
    .SUM1      (SUM1),
    .SUM2      (SUM2),
    .USE_SUM2  (USE_SUM2),
    .T1        (T1),
    .T2        (T2),
    .T3        (T3),
    .T4        (T4),
    .FIRST_BIT (FIRST_BIT),
    .WRITE_EN  (WRITE_EN),
    .A_OUT     (A_OUT),
    .DIGIT_OUT (DIGIT_OUT),
    .WORD_ZERO (WORD_ZERO)
  );

  // One full word cycle. rst_at >= 0 pulses RESET during that bit.
  task automatic run_word(input logic we, input logic [WB-1:0] s1,
                          input logic [WB-1:0] s2, input logic [WD-1:0] use2,
                          input int rst_at, input string tag);
    logic [WB-1:0] exp_prev;
    logic [WB-1:0] commit;
    logic [WB-1:0] observed;
    logic [WB-1:0] mask;
    logic [WB-1:0] one;
    logic [3:0]    d_exp;
    logic          wz_exp;
    logic          rs;
    int            bad_wz;
    one      = 1;
    observed = '0;
    mask     = '1;
    rs       = 1'b0;
    bad_wz   = 0;
    checks++;
    if (word_q.size() == 0) begin
      failures++;
      $display("FAIL %s word_queue act=empty req=entry", tag);
      exp_prev = '0;
    end else begin
      exp_prev = word_q.pop_front();
    end
    for (int d = 0; d < WD; d++) begin
      if (we) commit[4*d +: 4] = use2[d] ? s2[4*d +: 4] : s1[4*d +: 4];
      else    commit[4*d +: 4] = exp_prev[4*d +: 4];
    end
    for (int k = 0; k < WB; k++) begin
      @(negedge PHI2);
      if (rst_at >= 0 && k == rst_at + 1) RESET = 1'b0;
      observed[k] = A_OUT;
      if (WORD_ZERO !== wz_prev) bad_wz++;
      if (k % 4 == 0 && k > 0) begin
        d_exp = digit_q.pop_front();
        checks++;
        if (DIGIT_OUT !== d_exp) begin
          failures++;
          $display("FAIL %s digit%0d act=%h req=%h", tag, k / 4 - 1, DIGIT_OUT, d_exp);
        end
      end
      T1        = (k % 4 == 0);
      T2        = (k % 4 == 1);
      T3        = (k % 4 == 2);
      T4        = (k % 4 == 3);
      FIRST_BIT = (k == 0);
      WRITE_EN  = we;
      SUM1      = s1[k];
      SUM2      = s2[k];
      USE_SUM2  = (k % 4 == 3) && use2[k / 4];
      if (k % 4 == 3) digit_q.push_back(rs ? 4'h0 : commit[k-3 +: 4]);
      if (k == rst_at) begin
        RESET = 1'b1;
        #1;
        checks++;
        if (A_OUT !== 1'b0 || DIGIT_OUT !== 4'h0 || WORD_ZERO !== 1'b1) begin
          failures++;
          $display("FAIL %s async_reset act=%b/%h/%b req=0/0/1", tag, A_OUT, DIGIT_OUT, WORD_ZERO);
        end
        rs      = 1'b1;
        wz_prev = 1'b1;
        mask    = (one << k) - one;
        commit  = '0;
      end
    end
    @(posedge PHI2);
    #1;
    T1 = 1'b0; T2 = 1'b0; T3 = 1'b0; T4 = 1'b0; FIRST_BIT = 1'b0; USE_SUM2 = 1'b0;
    d_exp = digit_q.pop_front();
    checks++;
    if (DIGIT_OUT !== d_exp) begin
      failures++;
      $display("FAIL %s digit13 act=%h req=%h", tag, DIGIT_OUT, d_exp);
    end
    checks++;
    if ((observed & mask) !== (exp_prev & mask)) begin
      failures++;
      $display("FAIL %s a_out_word act=%h req=%h", tag, observed & mask, exp_prev & mask);
    end
    checks++;
    if (bad_wz != 0) begin
      failures++;
      $display("FAIL %s word_zero_stable act=%0d_changes req=0", tag, bad_wz);
    end
    wz_exp = rs ? 1'b1 : (commit == '0);
    checks++;
    if (WORD_ZERO !== wz_exp) begin
      failures++;
      $display("FAIL %s word_zero act=%b req=%b", tag, WORD_ZERO, wz_exp);
    end
    wz_prev = wz_exp;
    word_q.push_back(commit);
    $display("word %-14s we=%b read=%h committed=%h word_zero=%b", tag, we, observed, commit, WORD_ZERO);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge PHI2);
    checks++;
    if (A_OUT !== 1'b0 || DIGIT_OUT !== 4'h0 || WORD_ZERO !== 1'b1) begin
      failures++;
      $display("FAIL reset_state act=%b/%h/%b req=0/0/1", A_OUT, DIGIT_OUT, WORD_ZERO);
    end
    RESET = 1'b0;
    word_q.delete();
    digit_q.delete();
    word_q.push_back('0);
    wz_prev = 1'b1;
    $display("reset a_out=%b digit_out=%h word_zero=%b", A_OUT, DIGIT_OUT, WORD_ZERO);
  endtask

  task automatic test_idle_recirc();
    run_word(1'b0, '0, '0, '0, -1, "idle0");
    run_word(1'b0, '0, '0, '0, -1, "idle1");
  endtask

  task automatic test_add_corrected();
    logic [WB-1:0] s1;
    logic [WB-1:0] s2;
    s1 = '0; s2 = '0;
    s1[20 +: 4] = 4'hC;
    s2[20 +: 4] = 4'h2;
    run_word(1'b1, s1, s2, 14'h0020, -1, "add5p7");
    run_word(1'b0, '0, '0, '0, -1, "add5p7_rd");
  endtask

  task automatic test_add_uncorrected();
    logic [WB-1:0] s1;
    logic [WB-1:0] s2;
    s1 = '0; s2 = '0;
    s1[36 +: 4] = 4'h7;
    s2[36 +: 4] = 4'hD;
    run_word(1'b1, s1, s2, '0, -1, "add3p4");
    for (int i = 0; i < 3; i++) run_word(1'b0, '0, '0, '0, -1, "add3p4_rd");
  endtask

  task automatic test_pattern_load();
    run_word(1'b1, 56'h9876543210FEDC, 56'h0123456789ABCD, '0, -1, "pattern");
    run_word(1'b0, '0, '0, '0, -1, "pattern_rd0");
    run_word(1'b0, '0, '0, '0, -1, "pattern_rd1");
  endtask

  task automatic test_word_zero();
    logic [WB-1:0] s1;
    s1 = '0;
    s1[52 +: 4] = 4'h1;
    run_word(1'b1, '0, 56'hFFFFFFFFFFFFFF, '0, -1, "zero_word");
    run_word(1'b1, s1, '0, '0, -1, "digit13_one");
    run_word(1'b0, '0, '0, '0, -1, "digit13_rd");
  endtask

  task automatic test_back_to_back();
    logic [63:0]   r1;
    logic [63:0]   r2;
    logic [WD-1:0] u;
    for (int i = 0; i < 4; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      u  = WD'($urandom());
      run_word(1'b1, r1[WB-1:0], r2[WB-1:0], u, -1, "random");
    end
    run_word(1'b0, '0, '0, '0, -1, "random_rd");
  endtask

  task automatic test_reset_async();
    run_word(1'b1, 56'h9876543210FEDC, '0, '0, -1, "pre_reset");
    run_word(1'b0, '0, '0, '0, 30, "reset_bit30");
    run_word(1'b0, '0, '0, '0, -1, "post_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_recirc();
    test_add_corrected();
    test_add_uncorrected();
    test_pattern_load();
    test_word_zero();
    test_back_to_back();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
